// File: rtl/gcn_schedule_ctrl.sv
// Sequencer for the GCN combination datapath: walks every weight column against every feature row, then steps the COO edge list.
// Outputs are registered from the next state; the FSM stalls in WAIT_MAC on mac_valid and in AGG on agg_ready.
module gcn_schedule_ctrl #(
   parameter int FEATURE_ROWS          = 6,
   parameter int WEIGHT_COLS           = 3,
   parameter int ADDRESS_WIDTH         = 13,
   parameter int FEATURE_BASE          = 512,
   parameter int COO_NUM_OF_COLS       = 6,
   parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
   parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
   parameter int COO_BW                = $clog2(COO_NUM_OF_COLS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic                             enable_read,
   output logic [ADDRESS_WIDTH-1:0]         read_address,
   output logic                             load_weight,
   output logic                             load_feature,
   output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col,
   output logic [COUNTER_FEATURE_WIDTH-1:0] feature_row,
   input  logic                             mac_valid,
   output logic                             result_we,
   output logic [COO_BW-1:0]                coo_address,
   output logic                             agg_valid,
   input  logic                             agg_ready,
   output logic                             done
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_W, S_LD_W, S_RD_F, S_LD_F, S_WAIT_MAC, S_WRITE, S_AGG, S_DONE
   } state_t;

   localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_COL = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
   localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
   localparam logic [COO_BW-1:0]                LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);

   state_t                             r_state, w_state;
   logic [COUNTER_WEIGHT_WIDTH-1:0]    r_weight_col, w_weight_col;
   logic [COUNTER_FEATURE_WIDTH-1:0]   r_feature_row, w_feature_row;
   logic [COO_BW-1:0]                  r_coo_address, w_coo_address;
   logic [ADDRESS_WIDTH-1:0]           r_read_address, w_read_address;
   logic                               r_enable_read;
   logic                               r_load_weight;
   logic                               r_load_feature;
   logic                               r_result_we;
   logic                               r_agg_valid;
   logic                               r_done;

   always_comb begin
      w_state       = r_state;
      w_weight_col  = r_weight_col;
      w_feature_row = r_feature_row;
      w_coo_address = r_coo_address;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state       = S_RD_W;
               w_weight_col  = '0;
               w_feature_row = '0;
            end
         end
         S_RD_W:     w_state = S_LD_W;
         S_LD_W:     w_state = S_RD_F;
         S_RD_F:     w_state = S_LD_F;
         S_LD_F:     w_state = S_WAIT_MAC;
         S_WAIT_MAC: if (mac_valid) w_state = S_WRITE;
         S_WRITE: begin
            if (r_feature_row < LAST_ROW) begin
               w_feature_row = r_feature_row + 1'b1;
               w_state       = S_RD_F;
            end else if (r_weight_col < LAST_COL) begin
               w_feature_row = '0;
               w_weight_col  = r_weight_col + 1'b1;
               w_state       = S_RD_W;
            end else begin
               w_feature_row = '0;
               w_weight_col  = '0;
               w_coo_address = '0;
               w_state       = S_AGG;
            end
         end
         S_AGG: begin
            if (agg_ready) begin
               if (r_coo_address < LAST_EDGE) begin
                  w_coo_address = r_coo_address + 1'b1;
               end else begin
                  w_coo_address = '0;
                  w_state       = S_DONE;
               end
            end
         end
         S_DONE:  if (!start) w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      // The address is only loaded on entry to a read state; the load states and everything else hold it.
      w_read_address = r_read_address;
      if (w_state == S_RD_W) begin
         w_read_address = ADDRESS_WIDTH'(w_weight_col);
      end else if (w_state == S_RD_F) begin
         w_read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(w_feature_row);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_weight_col   <= '0;
         r_feature_row  <= '0;
         r_coo_address  <= '0;
         r_read_address <= '0;
         r_enable_read  <= 1'b0;
         r_load_weight  <= 1'b0;
         r_load_feature <= 1'b0;
         r_result_we    <= 1'b0;
         r_agg_valid    <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state;
         r_weight_col   <= w_weight_col;
         r_feature_row  <= w_feature_row;
         r_coo_address  <= w_coo_address;
         r_read_address <= w_read_address;
         r_enable_read  <= (w_state == S_RD_W) || (w_state == S_LD_W) ||
                           (w_state == S_RD_F) || (w_state == S_LD_F);
         r_load_weight  <= (w_state == S_LD_W);
         r_load_feature <= (w_state == S_LD_F);
         r_result_we    <= (w_state == S_WRITE);
         r_agg_valid    <= (w_state == S_AGG);
         r_done         <= (w_state == S_DONE);
      end
   end

   assign enable_read  = r_enable_read;
   assign read_address = r_read_address;
   assign load_weight  = r_load_weight;
   assign load_feature = r_load_feature;
   assign weight_col   = r_weight_col;
   assign feature_row  = r_feature_row;
   assign result_we    = r_result_we;
   assign coo_address  = r_coo_address;
   assign agg_valid    = r_agg_valid;
   assign done         = r_done;

endmodule

// File: tb/tb_gcn_schedule_ctrl.sv
// Directed bench for gcn_schedule_ctrl: strobe events are scored in order against an expected-event queue.
module tb_gcn_schedule_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        enable_read;
   logic [12:0] read_address;
   logic        load_weight;
   logic        load_feature;
   logic [1:0]  weight_col;
   logic [2:0]  feature_row;
   logic        mac_valid;
   logic        result_we;
   logic [2:0]  coo_address;
   logic        agg_valid;
   logic        agg_ready;
   logic        done;

   gcn_schedule_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .enable_read(enable_read), .read_address(read_address),
      .load_weight(load_weight), .load_feature(load_feature),
      .weight_col(weight_col), .feature_row(feature_row),
      .mac_valid(mac_valid), .result_we(result_we),
      .coo_address(coo_address), .agg_valid(agg_valid),
      .agg_ready(agg_ready), .done(done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   int          stall_left = 0;
   bit          stall_arm  = 1'b0;
   bit          mac_auto   = 1'b1;
   int          agg_mode   = 0;   // 0: ready high, 1: 1,0,0 pattern, 2: bench-driven
   int          agg_idx    = 0;

   function automatic logic [31:0] mk(input int kind, input int row, input int col, input int addr);
      return {4'(kind), 4'(row), 4'(col), 4'd0, 16'(addr)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic observe(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: observed %0h expected nothing (scoreboard empty)", tag, obs);
      end else begin
         e = exp_q.pop_front();
         check(tag, obs, e);
      end
   endtask

   task automatic push_run();
      for (int w = 0; w < 3; w++) begin
         exp_q.push_back(mk(1, 0, w, w));
         for (int r = 0; r < 6; r++) begin
            exp_q.push_back(mk(2, r, w, 512 + r));
            exp_q.push_back(mk(3, r, w, 512 + r));
         end
      end
      for (int c = 0; c < 6; c++) exp_q.push_back(mk(4, 0, 0, c));
   endtask

   // Called just after a falling edge: drive auto inputs, score visible strobes, advance one cycle.
   task automatic tick();
      if (mac_auto) begin
         if (stall_left > 0) begin
            mac_valid = 1'b0;
            stall_left--;
            check("stall_outputs", 32'({enable_read, result_we}), 32'd0);
         end else begin
            mac_valid = 1'b1;
         end
         if (stall_arm && load_feature && feature_row == 3'd2 && weight_col == 2'd1) begin
            stall_left = 5;
            stall_arm  = 1'b0;
         end
      end
      if (agg_mode == 0) begin
         agg_ready = 1'b1;
      end else if (agg_mode == 1) begin
         if (agg_valid) begin
            agg_ready = (agg_idx % 3 == 0);
            agg_idx++;
         end else begin
            agg_ready = 1'b0;
         end
      end
      if (load_weight || load_feature || result_we || agg_valid)
         check("onehot", 32'($countones({load_weight, load_feature, result_we, agg_valid}) <= 1), 32'd1);
      if (load_weight)  observe("load_weight",  mk(1, 0, int'(weight_col), int'(read_address)));
      if (load_feature) observe("load_feature", mk(2, int'(feature_row), int'(weight_col), int'(read_address)));
      if (result_we)    observe("result_we",    mk(3, int'(feature_row), int'(weight_col), int'(read_address)));
      if (agg_valid && agg_ready) observe("agg_accept", mk(4, 0, 0, int'(coo_address)));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to_done(input int pre, input int exp_lat, input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      check(tag, 32'(pre + n - 1), 32'(exp_lat));
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      reset     = 1'b0;
      start     = 1'b0;
      mac_valid = 1'b0;
      agg_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_strobes", 32'({enable_read, load_weight, load_feature, result_we, agg_valid, done}), 32'd0);
      check("rst_addr", 32'(read_address), 32'd0);
      check("rst_counters", 32'({weight_col, feature_row, coo_address}), 32'd0);
      reset = 1'b1;
      tick();

      // Full run with mac_valid and agg_ready high.
      push_run();
      start = 1'b1;
      run_to_done(0, 84, "lat_basic");

      // DONE holds while start stays high; no reads meanwhile.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("done_hold", 32'({done, enable_read}), 32'b10);
      end
      start = 1'b0;
      tick();
      check("done_fall", 32'(done), 32'd0);
      start = 1'b1;
      push_run();
      run_to_done(0, 84, "lat_second");
      start = 1'b0;
      tick();

      // Five-cycle mac_valid stall at row 2, col 1.
      stall_arm = 1'b1;
      push_run();
      start = 1'b1;
      run_to_done(0, 89, "lat_stall");
      check("stall_seen", 32'({stall_arm, 1'b0}), 32'd0);
      start = 1'b0;
      tick();

      // agg_ready pattern 1,0,0 repeating: 16 AGG cycles for 6 edges.
      agg_mode = 1;
      agg_idx  = 0;
      push_run();
      start = 1'b1;
      run_to_done(0, 94, "lat_agg_toggle");
      check("agg_cycles", 32'(agg_idx), 32'd16);
      agg_mode = 0;
      start    = 1'b0;
      tick();

      // Asynchronous reset in LD_F at row 3, col 2, then a clean restart.
      push_run();
      start = 1'b1;
      n = 0;
      while (!(load_feature && feature_row == 3'd3 && weight_col == 2'd2) && n < 200) begin
         tick();
         n++;
      end
      check("reach_ldf_r3c2", 32'(n < 200), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("midrst_strobes", 32'({enable_read, load_weight, load_feature, result_we, agg_valid, done}), 32'd0);
      check("midrst_addr", 32'(read_address), 32'd0);
      check("midrst_counters", 32'({weight_col, feature_row, coo_address}), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      push_run();
      run_to_done(0, 84, "lat_after_rst");
      start = 1'b0;
      tick();

      // Ignored inputs: agg_ready/mac_valid in IDLE, mac_valid pulse in RD_F.
      mac_auto  = 1'b0;
      agg_mode  = 2;
      agg_ready = 1'b1;
      mac_valid = 1'b1;
      tick();
      check("idle_ignore", 32'({done, agg_valid, result_we, enable_read}), 32'd0);
      agg_ready = 1'b0;
      mac_valid = 1'b0;
      push_run();
      start = 1'b1;
      repeat (3) tick();
      check("rdf_state", 32'({enable_read, load_feature, read_address}), 32'({1'b1, 1'b0, 13'd512}));
      mac_valid = 1'b1;
      tick();
      check("ldf_after_pulse", 32'({load_feature, result_we}), 32'b10);
      mac_valid = 1'b0;
      repeat (2) tick();
      check("wait_mac_hold", 32'({result_we, enable_read, agg_valid}), 32'd0);
      mac_auto = 1'b1;
      agg_mode = 0;
      run_to_done(6, 85, "lat_ignore");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gcn_schedule_ctrl.md
Name: gcn_schedule_ctrl

Overview:
Sequencing controller for the GCN combination datapath. It drives the single shared feature/weight memory read port, walking every weight column against every feature row. It strobes the transformation MAC and collects each dot product into a result slot. It then steps the COO edge list for the aggregation stage and raises done.

Parameters:
FEATURE_ROWS, 6, rows of feature matrix (graph nodes)
WEIGHT_COLS, 3, columns of weight matrix (output features)
ADDRESS_WIDTH, 13, memory read address width
FEATURE_BASE, 512, read address of feature row 0; weight column w is read at address w
COO_NUM_OF_COLS, 6, number of COO edges
COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), weight column counter width
COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), feature row counter width
COO_BW, $clog2(COO_NUM_OF_COLS), edge index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level request; sampled only in IDLE
enable_read  out  1  memory read enable
read_address  out  ADDRESS_WIDTH  memory read address
load_weight  out  1  datapath captures data_in as weight column weight_col
load_feature  out  1  datapath captures data_in as feature row feature_row
weight_col  out  COUNTER_WEIGHT_WIDTH  current weight column
feature_row  out  COUNTER_FEATURE_WIDTH  current feature row
mac_valid  in  1  datapath dot product for (feature_row, weight_col) is ready
result_we  out  1  write dot product into result[feature_row][weight_col]
coo_address  out  COO_BW  current COO edge index
agg_valid  out  1  COO edge at coo_address presented to aggregation
agg_ready  in  1  aggregation accepted current edge
done  out  1  all combination work complete

Behaviour:
- Outputs are Moore-decoded from registered state and counters. No input-to-output combinational path.
- Reset (reset=0, any time, including mid-sequence): state is IDLE. All counters and outputs are 0. Any partial sequence is discarded.
- States: IDLE, RD_W, LD_W, RD_F, LD_F, WAIT_MAC, WRITE, AGG, DONE.
- IDLE: if start=1, go to RD_W with weight_col=0 and feature_row=0.
- RD_W: enable_read=1, read_address=weight_col (zero-extended). Go to LD_W.
- LD_W: enable_read and read_address are held, load_weight=1. Go to RD_F.
- RD_F: enable_read=1, read_address=FEATURE_BASE+feature_row. Go to LD_F.
- LD_F: enable_read and read_address are held, load_feature=1. Go to WAIT_MAC.
- WAIT_MAC: stay until mac_valid=1. When mac_valid=1, go to WRITE.
- WRITE: result_we=1.
  - If feature_row<FEATURE_ROWS-1: increment feature_row and go to RD_F.
  - Else if weight_col<WEIGHT_COLS-1: feature_row wraps to 0, weight_col increments, go to RD_W.
  - Else: both wrap to 0, coo_address=0, go to AGG.
- AGG: agg_valid=1. When agg_ready=1 in the same cycle, the edge is accepted.
  - If coo_address<COO_NUM_OF_COLS-1: increment coo_address.
  - Else: go to DONE with coo_address=0.
  - agg_valid stays high across consecutive edges.
- DONE: done=1. Hold while start=1. Go to IDLE when start=0. done falls in IDLE.
- enable_read=0 in every state other than RD_W, LD_W, RD_F and LD_F. read_address holds its last value when enable_read=0.
- Ignored inputs:
  - start outside IDLE (no restart mid-run).
  - mac_valid outside WAIT_MAC.
  - agg_ready outside AGG.
- At most one of load_weight, load_feature, result_we, agg_valid is high in any cycle.
- Timing, with mac_valid and agg_ready tied high:
  - 2+4*FEATURE_ROWS cycles per weight column.
  - Total from the start-sampling edge to DONE entry = WEIGHT_COLS*(2+4*FEATURE_ROWS)+COO_NUM_OF_COLS cycles.
  - Defaults give 84.
- read_address arithmetic is ADDRESS_WIDTH-bit unsigned; FEATURE_BASE+FEATURE_ROWS-1 must fit.

Test Plan:
- Reset then start=1, mac_valid=agg_ready=1 (defaults): done rises exactly 84 cycles after the start edge. Exactly 3 load_weight pulses at addresses 0,1,2. Exactly 18 load_feature pulses at addresses 512..517 per column. Exactly 18 result_we pulses covering every (row,col) pair once, row-major within each column. Exactly 6 agg_valid cycles with coo_address 0..5.
- mac_valid held low 5 cycles in WAIT_MAC for row 2, col 1: FSM stalls in WAIT_MAC with enable_read=0 and result_we=0. It resumes on mac_valid=1, and the total run extends by exactly 5 cycles.
- agg_ready toggling 1,0,0,1,...: coo_address advances only on agg_ready=1 cycles. agg_valid stays high throughout AGG. done follows acceptance of edge 5.
- reset=0 asserted asynchronously mid-run in LD_F (row 3, col 2): all outputs drop to 0 immediately. After release with start=1, the sequence restarts from weight_col=0 and address 0.
- In DONE, hold start=1 for 10 cycles: done stays 1 and no read occurs. With start=0, FSM returns to IDLE and done=0. Reasserting start runs a second full 84-cycle sequence.
- mac_valid pulsed during RD_F and agg_ready pulsed in IDLE: no state change, and no result_we or agg_valid.
